// File: rtl/key_cond_pkg.sv
// Shared types, default timing and helpers for the key conditioner.
package key_cond_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DB_PRESS = 3'd1,
        PRESSED  = 3'd2,
        HELD     = 3'd3,
        DB_REL   = 3'd4
    } kc_state_e;

    // 20 ms, 1 s and 200 ms at 50 MHz.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;
    localparam int unsigned DEF_HOLD_CYCLES     = 50_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES   = 10_000_000;

    // Counter width wide enough for the largest interval (it only ever
    // counts up to interval-1).
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_cond_ch.sv
// One key channel: synchroniser, debounce/long-press FSM and shared counter.
module key_cond_ch
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_hold,
    output logic key_repeat
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);
    localparam logic [CW-1:0] ONE       = CW'(1);

    logic            sync1, s;
    kc_state_e       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            level_d, hold_d, press_d, rel_d, rep_d;

    // Two-flop synchroniser on the inverted raw button (1 = pressed).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= ~key_n;
            s     <= sync1;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            key_level   <= 1'b0;
            key_hold    <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_level   <= level_d;
            key_hold    <= hold_d;
            key_press   <= press_d;
            key_release <= rel_d;
            key_repeat  <= rep_d;
        end
    end

    // Next-state, counter and output decode; s=0 beats a terminal count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = key_level;
        hold_d  = key_hold;
        press_d = 1'b0;
        rel_d   = 1'b0;
        rep_d   = 1'b0;
        case (state_q)
            // Debounce entry loads 1: the entry edge is itself the first
            // stable cycle, so press/release land DEBOUNCE_CYCLES+2 edges
            // after the raw change.
            IDLE: begin
                if (s) begin
                    state_d = DB_PRESS;
                    cnt_d   = ONE;
                end
            end
            DB_PRESS: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = DB_REL;
                    cnt_d   = ONE;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    hold_d  = 1'b1;
                    rep_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = DB_REL;
                    cnt_d   = ONE;
                end else if (cnt_q == REP_LAST) begin
                    cnt_d = '0;
                    rep_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            DB_REL: begin
                if (s) begin
                    state_d = key_hold ? HELD : PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    hold_d  = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/key_conditioner.sv
// Top: N_KEYS independent debounced key channels for the key PIO.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int unsigned N_KEYS          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n_i,
    output logic [N_KEYS-1:0] key_level_o,
    output logic [N_KEYS-1:0] key_press_o,
    output logic [N_KEYS-1:0] key_release_o,
    output logic [N_KEYS-1:0] key_hold_o,
    output logic [N_KEYS-1:0] key_repeat_o
);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_cond_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_n       (key_n_i[g]),
            .key_level   (key_level_o[g]),
            .key_press   (key_press_o[g]),
            .key_release (key_release_o[g]),
            .key_hold    (key_hold_o[g]),
            .key_repeat  (key_repeat_o[g])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with a run-length reference model.
module tb_key_conditioner;

    localparam int unsigned NK = 3;
    localparam int DB = 4;
    localparam int HC = 20;
    localparam int RC = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_n_i;
    logic [NK-1:0] key_level_o, key_press_o, key_release_o, key_hold_o, key_repeat_o;

    always #5 clk = ~clk;

    key_conditioner #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HC),
        .REPEAT_CYCLES   (RC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_n_i       (key_n_i),
        .key_level_o   (key_level_o),
        .key_press_o   (key_press_o),
        .key_release_o (key_release_o),
        .key_hold_o    (key_hold_o),
        .key_repeat_o  (key_repeat_o)
    );

    typedef struct {
        int            cyc;
        logic [NK-1:0] press, rel, rep, lvl, hold;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;

    // Reference model: a key is accepted once its synchronised value has
    // held for DB consecutive edges; long-press/repeat are timed from the
    // press or from the last return to 1 after a release bounce.
    logic [NK-1:0] d1 = '0, d2 = '0, last_s = '0, m_lvl = '0, m_hold = '0;
    int            run[NK];
    int            anchor[NK];
    exp_t          me;
    logic          sv;

    always @(posedge clk) begin
        cyc = cyc + 1;
        me.press = '0; me.rel = '0; me.rep = '0;
        if (!rst_n) begin
            d1 = '0; d2 = '0; last_s = '0; m_lvl = '0; m_hold = '0;
            for (int i = 0; i < NK; i++) begin
                run[i] = 0;
                anchor[i] = 0;
            end
        end else begin
            for (int i = 0; i < NK; i++) begin
                sv = d2[i];
                d2[i] = d1[i];
                d1[i] = ~key_n_i[i];
                if (sv == last_s[i]) run[i] = run[i] + 1;
                else run[i] = 1;
                last_s[i] = sv;
                if (!m_lvl[i]) begin
                    if (sv && run[i] == DB) begin
                        m_lvl[i] = 1'b1;
                        m_hold[i] = 1'b0;
                        me.press[i] = 1'b1;
                        anchor[i] = cyc;
                    end
                end else if (!sv) begin
                    if (run[i] == DB) begin
                        m_lvl[i] = 1'b0;
                        m_hold[i] = 1'b0;
                        me.rel[i] = 1'b1;
                    end
                end else if (run[i] == 1) begin
                    anchor[i] = cyc;
                end else if (!m_hold[i] && cyc - anchor[i] == HC) begin
                    m_hold[i] = 1'b1;
                    me.rep[i] = 1'b1;
                    anchor[i] = cyc;
                end else if (m_hold[i] && cyc - anchor[i] == RC) begin
                    me.rep[i] = 1'b1;
                    anchor[i] = cyc;
                end
            end
            if (|{me.press, me.rel, me.rep}) begin
                me.cyc  = cyc;
                me.lvl  = m_lvl;
                me.hold = m_hold;
                q.push_back(me);
            end
        end
    end

    // Monitor: pops expected pulse records when the DUT presents a pulse.
    exp_t ge;
    always @(negedge clk) begin
        if (mon_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL missed_pulse: cycle %0d expected press=%b rel=%b rep=%b, got none",
                         q[0].cyc, q[0].press, q[0].rel, q[0].rep);
                void'(q.pop_front());
            end
            total = total + 1;
            if (key_level_o !== m_lvl || key_hold_o !== m_hold) begin
                bad = bad + 1;
                $display("FAIL level_hold: cycle %0d got level=%b hold=%b want level=%b hold=%b",
                         cyc, key_level_o, key_hold_o, m_lvl, m_hold);
            end
            if (|{key_press_o, key_release_o, key_repeat_o}) begin
                total = total + 1;
                if (q.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL unexpected_pulse: cycle %0d got press=%b rel=%b rep=%b want none",
                             cyc, key_press_o, key_release_o, key_repeat_o);
                end else begin
                    ge = q.pop_front();
                    if (ge.cyc != cyc || ge.press !== key_press_o || ge.rel !== key_release_o ||
                        ge.rep !== key_repeat_o || ge.lvl !== key_level_o || ge.hold !== key_hold_o) begin
                        bad = bad + 1;
                        $display("FAIL pulse: cycle %0d got p=%b r=%b rp=%b l=%b h=%b want cycle %0d p=%b r=%b rp=%b l=%b h=%b",
                                 cyc, key_press_o, key_release_o, key_repeat_o, key_level_o, key_hold_o,
                                 ge.cyc, ge.press, ge.rel, ge.rep, ge.lvl, ge.hold);
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        total = total + 1;
        if ({key_level_o, key_press_o, key_release_o, key_hold_o, key_repeat_o} !== '0) begin
            bad = bad + 1;
            $display("FAIL %s: got l=%b p=%b r=%b h=%b rp=%b want all 0", name,
                     key_level_o, key_press_o, key_release_o, key_hold_o, key_repeat_o);
        end
    endtask

    initial begin
        int len;
        rst_n   = 1'b0;
        key_n_i = '1;
        wait_cyc(3);
        check_all_zero("reset_state");
        rst_n  = 1'b1;
        mon_en = 1'b1;
        wait_cyc(5);

        // Clean press on key 0.
        key_n_i[0] = 1'b0; wait_cyc(15);
        key_n_i[0] = 1'b1; wait_cyc(15);

        // Bounce rejection on key 1.
        key_n_i[1] = 1'b0; wait_cyc(3);
        key_n_i[1] = 1'b1; wait_cyc(2);
        key_n_i[1] = 1'b0; wait_cyc(2);
        key_n_i[1] = 1'b1; wait_cyc(15);

        // Long hold on key 2.
        key_n_i[2] = 1'b0; wait_cyc(45);
        key_n_i[2] = 1'b1; wait_cyc(15);

        // Release bounce while held on key 0.
        key_n_i[0] = 1'b0; wait_cyc(35);
        key_n_i[0] = 1'b1; wait_cyc(2);
        key_n_i[0] = 1'b0; wait_cyc(15);
        key_n_i[0] = 1'b1; wait_cyc(15);

        // Independence: all pressed together, only key 1 released.
        key_n_i = '0;   wait_cyc(10);
        key_n_i[1] = 1'b1; wait_cyc(10);
        key_n_i = '1;   wait_cyc(15);

        // Reset while key 0 is held; key stays pressed afterwards.
        key_n_i[0] = 1'b0; wait_cyc(30);
        rst_n = 1'b0; wait_cyc(1);
        check_all_zero("reset_mid_hold");
        rst_n = 1'b1; wait_cyc(12);
        key_n_i[0] = 1'b1; wait_cyc(15);

        // Randomised bursts with occasional resets.
        for (int it = 0; it < 200; it++) begin
            key_n_i = key_n_i ^ 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) len = $urandom_range(1, 4);
            else len = $urandom_range(5, 40);
            if ($urandom_range(0, 40) == 0) begin
                rst_n = 1'b0; wait_cyc(1);
                check_all_zero("reset_random");
                rst_n = 1'b1;
            end
            wait_cyc(len);
        end

        key_n_i = '1;
        wait_cyc(30);
        mon_en = 1'b0;
        while (q.size() > 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL leftover_pulse: cycle %0d expected press=%b rel=%b rep=%b never seen",
                     q[0].cyc, q[0].press, q[0].rel, q[0].rep);
            void'(q.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
